bus_dispatcher: RTL and testbench



---
 rtl/bus_dispatcher_pkg.sv | 24 ++
 rtl/bus_dispatcher_if.sv | 28 ++
 rtl/disp_rr_ptr.sv | 54 +++++
 rtl/bus_dispatcher.sv | 97 +++++++++
 tb/tb_bus_dispatcher.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_dispatcher_pkg.sv
// Shared message codes, slot index codes and dispatcher state encodings
// used by the dispatcher, its pointer sub-module and the bridges.
package bus_dispatcher_pkg;

  localparam int IDX_W_DEF = 32;

  localparam logic [7:0] CPU_R_RESET = 8'h01;
  localparam logic [7:0] CPU_R_START = 8'h02;
  localparam logic [7:0] CPU_R_END   = 8'h03;

  // Top bit flags an active slot number; the start slot has its own code.
  localparam logic [IDX_W_DEF-1:0] CPU_ACTIVE    = 32'h8000_0000;
  localparam logic [IDX_W_DEF-1:0] CPU_NONACTIVE = 32'h4000_0000;

  localparam logic [2:0] S_RST      = 3'd0;
  localparam logic [2:0] S_RST_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_POLL     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_XFER     = 3'd5;
  localparam logic [2:0] S_REL      = 3'd6;
  localparam logic [2:0] S_NEXT     = 3'd7;

endpackage

// File: rtl/bus_dispatcher_if.sv
// Shared external CPU bus between the dispatcher (master) and the bridges (slave).
// Wired-OR request/reset-done lines plus the token offer/acknowledge handshake.
interface bus_dispatcher_if #(
  parameter int IDX_W = 32
);
  logic             ext_rst_b;
  logic             ext_rst_e;
  logic             ext_dispatcher_q;
  logic             ext_next_cpu_q;
  logic [IDX_W-1:0] ext_cpu_index;
  logic             ext_next_cpu_e;
  logic [7:0]       ext_cpu_msg;
  logic             ext_read_q;
  logic             ext_write_q;
  logic             ext_bus_busy;

  modport master (
    output ext_rst_b, ext_next_cpu_q, ext_cpu_index, ext_bus_busy,
    input  ext_rst_e, ext_dispatcher_q, ext_next_cpu_e, ext_cpu_msg,
           ext_read_q, ext_write_q
  );

  modport slave (
    input  ext_rst_b, ext_next_cpu_q, ext_cpu_index, ext_bus_busy,
    output ext_rst_e, ext_dispatcher_q, ext_next_cpu_e, ext_cpu_msg,
           ext_read_q, ext_write_q
  );
endinterface

// File: rtl/disp_rr_ptr.sv
// Round-robin slot pointer and active CPU count; updates on the ack cycle,
// advances one cycle after the grant ends. No backpressure: strobes act immediately.
module disp_rr_ptr
  import bus_dispatcher_pkg::*;
#(
  parameter int CPU_NUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll,
  input  logic       ack,
  input  logic [7:0] msg,
  input  logic       advance,
  output logic [7:0] ptr,
  output logic [7:0] active_cnt,
  output logic       at_start
);
  localparam logic [7:0] CNT_MAX = 8'(CPU_NUM);

  logic       served_start;
  logic [7:0] cnt_dec;
  logic [8:0] ptr_inc;
  logic       wrap;

  assign at_start = (ptr >= active_cnt);
  assign cnt_dec  = (active_cnt == 8'd0) ? 8'd0 : active_cnt - 8'd1;
  assign ptr_inc  = {1'b0, ptr} + 9'd1;
  // A served start slot always wraps, even if START just made ptr an active slot.
  assign wrap = served_start || (ptr_inc > {1'b0, active_cnt}) ||
                ((ptr_inc == {1'b0, active_cnt}) && (active_cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= 8'd0;
      active_cnt   <= 8'd0;
      served_start <= 1'b0;
    end else begin
      if (poll)
        served_start <= at_start;
      if (ack) begin
        if (msg == CPU_R_START) begin
          if (active_cnt < CNT_MAX)
            active_cnt <= active_cnt + 8'd1;
        end else if (msg == CPU_R_END) begin
          active_cnt <= cnt_dec;
          if (ptr > cnt_dec)
            ptr <= 8'd0;
        end
      end
      if (advance)
        ptr <= wrap ? 8'd0 : ptr_inc[7:0];
    end
  end
endmodule

// File: rtl/bus_dispatcher.sv
// Bus token arbiter: resets the bridges, polls slots round-robin, holds the bus per grant.
// Grant turnaround >= 4 cycles; bridges stall the dispatcher by holding ext_next_cpu_e (bounded by TIMEOUT).
module bus_dispatcher
  import bus_dispatcher_pkg::*;
#(
  parameter int CPU_NUM    = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 16,
  parameter int IDX_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  bus_dispatcher_if.master        bus,
  output logic [7:0]              active_cnt,
  output logic                    grant_valid,
  output logic                    timeout_err
);
  localparam logic [7:0]  CNT_MAX  = 8'(CPU_NUM);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]  state, state_nxt;
  logic [15:0] cnt;
  logic        to_hit;
  logic [7:0]  ptr;
  logic        at_start;
  logic        offer;

  disp_rr_ptr #(.CPU_NUM(CPU_NUM)) u_rr_ptr (
    .clk        (clk),
    .rst        (rst),
    .poll       (state == S_POLL),
    .ack        ((state == S_ACK) && bus.ext_next_cpu_e),
    .msg        (bus.ext_cpu_msg),
    .advance    (state == S_NEXT),
    .ptr        (ptr),
    .active_cnt (active_cnt),
    .at_start   (at_start)
  );

  always_comb begin
    state_nxt = state;
    to_hit    = 1'b0;
    case (state)
      S_RST:      if (cnt >= RST_LAST) state_nxt = S_RST_WAIT;
      S_RST_WAIT: begin
        if (bus.ext_rst_e) begin
          state_nxt = S_IDLE;
        end else if (cnt >= TO_LAST) begin
          state_nxt = S_IDLE;
          to_hit    = 1'b1;
        end
      end
      S_IDLE:     if (bus.ext_dispatcher_q || (active_cnt < CNT_MAX)) state_nxt = S_POLL;
      S_POLL:     state_nxt = S_ACK;
      S_ACK: begin
        if (bus.ext_next_cpu_e) begin
          state_nxt = (bus.ext_read_q || bus.ext_write_q) ? S_XFER : S_REL;
        end else if (cnt >= TO_LAST) begin
          state_nxt = S_NEXT;
          to_hit    = 1'b1;
        end
      end
      S_XFER, S_REL: begin
        if (!bus.ext_next_cpu_e) begin
          state_nxt = S_NEXT;
        end else if (cnt >= TO_LAST) begin
          state_nxt = S_NEXT;
          to_hit    = 1'b1;
        end
      end
      S_NEXT:     state_nxt = S_IDLE;
      default:    state_nxt = S_RST;
    endcase
  end

  // One wait counter shared by all states; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST;
      cnt         <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      timeout_err <= to_hit;
    end
  end

  assign offer              = (state == S_POLL) || (state == S_ACK);
  assign bus.ext_rst_b      = (state == S_RST);
  assign bus.ext_next_cpu_q = offer;
  assign bus.ext_bus_busy   = (state == S_XFER);
  assign grant_valid        = (state == S_XFER) || (state == S_REL);
  assign bus.ext_cpu_index  = (offer && !at_start) ? (IDX_W'(CPU_ACTIVE) | IDX_W'(ptr))
                                                   : IDX_W'(CPU_NONACTIVE);
endmodule

// File: tb/tb_bus_dispatcher.sv
// Randomised bridge responses against a slot-list reference model; a monitor
// scores every poll (index, active count) and the preceding grant's busy/grant/timeout cycles.
module tb_bus_dispatcher;
  import bus_dispatcher_pkg::*;

  localparam int CPU_NUM    = 4;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;
  localparam int IDX_W      = 32;
  localparam int N_GRANTS   = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] active_cnt;
  logic       grant_valid;
  logic       timeout_err;

  bus_dispatcher_if #(.IDX_W(IDX_W)) bus ();

  bus_dispatcher #(
    .CPU_NUM(CPU_NUM), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .active_cnt  (active_cnt),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] idx;
    int          cnt;
    int          busy;
    int          gv;
    int          err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference model: -1 names the start slot, otherwise the active slot number.
  int m_cnt  = 0;
  int m_slot = -1;

  function automatic void check(string name, longint got, longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  function automatic logic [31:0] slot_index(int s);
    return (s < 0) ? CPU_NONACTIVE : (CPU_ACTIVE | 32'(s));
  endfunction

  // Poll order is active slots 0..cnt-1 then the start slot (absent when full).
  function automatic void model_step(bit acked, logic [7:0] msg);
    int order[$];
    bit was_start;
    was_start = (m_slot < 0);
    if (acked && msg == CPU_R_START && m_cnt < CPU_NUM) m_cnt++;
    if (acked && msg == CPU_R_END && m_cnt > 0) m_cnt--;
    for (int i = 0; i < m_cnt; i++) order.push_back(i);
    if (m_cnt < CPU_NUM) order.push_back(-1);
    if (was_start || m_slot >= m_cnt) m_slot = order[0];
    else m_slot = order[(m_slot + 1) % order.size()];
  endfunction

  task automatic wait_poll(output bit ok);
    bit seen_low;
    seen_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!bus.ext_next_cpu_q) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : monitor
    bit   q_prev;
    int   busy, gv, err;
    exp_t ex;
    q_prev = 1'b0;
    busy = 0; gv = 0; err = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        busy += int'(bus.ext_bus_busy);
        gv   += int'(grant_valid);
        err  += int'(timeout_err);
        if (bus.ext_next_cpu_q && !q_prev) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_poll: got index %0h, expected no poll", bus.ext_cpu_index);
          end else begin
            ex = sb.pop_front();
            check("poll_index", bus.ext_cpu_index, ex.idx);
            check("poll_active_cnt", active_cnt, ex.cnt);
            check("busy_cycles", busy, ex.busy);
            check("grant_cycles", gv, ex.gv);
            check("timeout_pulses", err, ex.err);
          end
          busy = 0; gv = 0; err = 0;
        end
        q_prev = bus.ext_next_cpu_q;
      end
    end
  end

  initial begin : stim
    bit         ok, alive;
    int         rst_b_cycles, rst_errs, d, h, kind, rw;
    logic [7:0] msg;
    exp_t       ex;

    alive = 1'b1;
    ok    = 1'b0;
    rst   = 1'b1;
    bus.ext_rst_e        = 1'b0;
    bus.ext_dispatcher_q = 1'b1;
    bus.ext_next_cpu_e   = 1'b0;
    bus.ext_cpu_msg      = 8'h00;
    bus.ext_read_q       = 1'b0;
    bus.ext_write_q      = 1'b0;

    @(negedge clk);
    check("rst_ext_rst_b", bus.ext_rst_b, 1);
    check("rst_next_cpu_q", bus.ext_next_cpu_q, 0);
    check("rst_cpu_index", bus.ext_cpu_index, CPU_NONACTIVE);
    check("rst_bus_busy", bus.ext_bus_busy, 0);
    check("rst_active_cnt", active_cnt, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_timeout_err", timeout_err, 0);

    ex = '{idx: CPU_NONACTIVE, cnt: 0, busy: 0, gv: 0, err: 0};
    sb.push_back(ex);
    rst    = 1'b0;
    mon_en = 1'b1;
    rst_b_cycles = int'(bus.ext_rst_b);
    rst_errs     = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 2) bus.ext_rst_e = 1'b1;
      rst_b_cycles += int'(bus.ext_rst_b);
      rst_errs     += int'(timeout_err);
      if (bus.ext_next_cpu_q) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_b_high_cycles", rst_b_cycles, RST_CYCLES);
    check("rst_wait_timeouts", rst_errs, 0);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL first_poll: got none within 60 cycles, expected a poll");
      alive = 1'b0;
    end

    for (int g = 0; g < N_GRANTS && alive; g++) begin
      kind = $urandom_range(0, 7);
      ex.busy = 0; ex.gv = 0; ex.err = 0;
      if (kind == 0) begin
        model_step(1'b0, 8'h00);
        ex.err = 1;
      end else begin
        d  = $urandom_range(1, 3);
        h  = (kind == 1) ? $urandom_range(TIMEOUT, TIMEOUT + 1) : $urandom_range(1, 7);
        rw = $urandom_range(0, 2);
        if (m_slot < 0) msg = ($urandom_range(0, 3) != 0) ? CPU_R_START : 8'h5A;
        else            msg = ($urandom_range(0, 4) == 0) ? CPU_R_END : 8'hA5;
        model_step(1'b1, msg);
        ex.gv   = (h > TIMEOUT) ? TIMEOUT : h;
        ex.busy = (rw != 0) ? ex.gv : 0;
        ex.err  = (h > TIMEOUT) ? 1 : 0;
        repeat (d) @(negedge clk);
        bus.ext_next_cpu_e = 1'b1;
        bus.ext_cpu_msg    = msg;
        bus.ext_read_q     = (rw == 1);
        bus.ext_write_q    = (rw == 2);
        repeat (h) @(negedge clk);
        bus.ext_next_cpu_e = 1'b0;
        bus.ext_cpu_msg    = 8'h00;
        bus.ext_read_q     = 1'b0;
        bus.ext_write_q    = 1'b0;
      end
      ex.idx = slot_index(m_slot);
      ex.cnt = m_cnt;
      sb.push_back(ex);
      wait_poll(ok);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL poll_wait: got no poll within 120 cycles at grant %0d, expected a poll", g);
        alive = 1'b0;
      end
    end

    if (alive) begin
      // Reset while a read transfer owns the bus: no draining.
      @(negedge clk);
      mon_en = 1'b0;
      bus.ext_next_cpu_e = 1'b1;
      bus.ext_read_q     = 1'b1;
      repeat (3) @(negedge clk);
      check("xfer_bus_busy", bus.ext_bus_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("xfer_rst_bus_busy", bus.ext_bus_busy, 0);
      check("xfer_rst_next_cpu_q", bus.ext_next_cpu_q, 0);
      check("xfer_rst_active_cnt", active_cnt, 0);
      check("xfer_rst_ext_rst_b", bus.ext_rst_b, 1);
      check("xfer_rst_grant_valid", grant_valid, 0);
      rst = 1'b0;
      bus.ext_next_cpu_e = 1'b0;
      bus.ext_read_q     = 1'b0;
      check("scoreboard_drained", sb.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
